ntt_input_loader: RTL
=====================

# ntt_input_loader

Upstream feeder for the NTT BRAM stage. It accepts a host word stream over a valid/ready handshake and writes the x vector, then the twiddle matrix, into the shared BRAM. It then releases the NTT stage from reset and waits for that stage's completion. It owns the BRAM port during the load and hands the port to the NTT stage afterwards.

## Interface
- X_LEN, 64, number of x words
- W_LEN, 4096, number of twiddle words (64×64; only bits [7:0] are meaningful)
- X_BASE, 0, word index of x[0]
- W_BASE, 128, word index of w[0][0]
- ADDR_W, 15, BRAM byte-address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request to begin a load; ignored unless in IDLE or DONE
- s_valid  in  1  host word valid
- s_data  in  64  host word
- s_last  in  1  marks the final word of a load (word 4159)
- s_ready  out  1  loader accepts a word this cycle
- BRAM_addr  out  ADDR_W  byte address (word index << 2)
- BRAM_din  out  64  write data
- BRAM_en  out  1  port enable
- BRAM_we  out  1  write enable
- bram_owner  out  1  0 = this block drives the BRAM port; 1 = NTT stage drives it
- ntt_rst  out  1  reset to the NTT stage
- ntt_done  in  1  completion flag from the NTT stage
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse when ntt_done is first seen
- err  out  1  sticky framing error; cleared by rst or an accepted start

## Operation
- States: IDLE → LOAD_X → LOAD_W → RELEASE → WAIT_NTT → DONE.
- IDLE / DONE: s_ready=0.
  - IDLE: bram_owner=0, ntt_rst=1.
  - DONE: bram_owner=1, ntt_rst=0, so the result stays readable.
  - start → LOAD_X, word counter cleared, ntt_rst=1, bram_owner=0.
- LOAD_X:
  - s_ready=1.
  - Each handshake writes s_data to word index X_BASE+cnt.
  - After X_LEN handshakes → LOAD_W with cnt=0.
- LOAD_W:
  - s_ready=1.
  - Each handshake writes s_data to word index W_BASE+cnt.
  - After W_LEN handshakes → RELEASE.
- Framing:
  - s_last on any handshake other than word X_LEN+W_LEN−1: set err, go to IDLE; that word is not written.
  - s_last absent on the final word: set err, go to IDLE; that word is written.
- RELEASE:
  - Lasts one cycle, so the final write completes.
  - Then ntt_rst=0 and bram_owner=1 → WAIT_NTT.
- WAIT_NTT: wait for ntt_done=1 → DONE, with a done pulse on entry.
- start in LOAD_X, LOAD_W, RELEASE or WAIT_NTT is ignored.
- Counter is 13 bits; wrap is impossible by construction because state advances at terminal count.

## Timing
- Reset values:
  - s_ready=0, BRAM_en=0, BRAM_we=0, BRAM_addr=0, BRAM_din=0
  - bram_owner=0, ntt_rst=1, busy=0, done=0, err=0
  - state=IDLE, cnt=0
- Write latency: BRAM_we/en/addr/din are registered and assert on the cycle after the handshake; each write is held exactly one cycle.
- Throughput: one word per cycle. A full load with continuous s_valid takes 4160 cycles, plus 1 cycle of start latency.
- s_ready is a registered function of state only and never depends on s_valid. It drops on the cycle after the terminal handshake.
- ntt_rst falls and bram_owner rises in the same cycle, 2 cycles after the last handshake (1 cycle of write latency, plus RELEASE).
- done rises 1 cycle after ntt_done is sampled high. It is not re-pulsed while ntt_done stays high.
- rst mid-load: all outputs return to their reset values on the next edge and the partial BRAM contents are abandoned. ntt_rst=1 holds the NTT stage idle.
- start and s_valid in the same IDLE cycle: only start is acted on; s_ready is still 0, so no word is consumed.

## Test plan
- Nominal load, continuous valid, s_data=index, s_last on word 4159:
  - word 0 → addr 0; word 63 → addr 252; word 64 → addr 512; word 4159 → addr 16892
  - ntt_rst falls 2 cycles after the last handshake
  - ntt_done=1 → done pulse 1 cycle later, busy=0
- Random s_valid gaps (≈30% idle) → the same 4160 writes, in order, with no duplicate or skipped addresses.
- s_last on word 100 → err=1, state IDLE, ntt_rst stays 1, no write to addr (W_BASE+36)<<2.
- rst asserted at word 2000 → next cycle all outputs at reset values; a new start then reloads from addr 0.
- start pulsed during LOAD_W and during WAIT_NTT → no state change and no counter change.
- Second start from DONE → err cleared, bram_owner returns to 0 and ntt_rst to 1 on the next cycle, and the load repeats correctly.

Source files
------------

// File: rtl/ntt_input_loader.sv
// ntt_input_loader: streams the x vector and twiddle matrix from the host into the
// shared BRAM, then releases the NTT stage and waits for its completion.
`default_nettype none

module ntt_input_loader #(
  parameter int X_LEN  = 64,
  parameter int W_LEN  = 4096,
  parameter int X_BASE = 0,
  parameter int W_BASE = 128,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [63:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] BRAM_addr,
  output logic [63:0]       BRAM_din,
  output logic              BRAM_en,
  output logic              BRAM_we,
  output logic              bram_owner,
  output logic              ntt_rst,
  input  logic              ntt_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = 13;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_X   = 3'd1,
    LOAD_W   = 3'd2,
    RELEASE  = 3'd3,
    WAIT_NTT = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               s_ready_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [63:0]        din_q;
  logic               en_q;
  logic               we_q;
  logic               owner_q;
  logic               ntt_rst_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               hs_d;
  logic               final_d;
  logic               x_term_d;
  logic [ADDR_W-1:0]  word_d;

  // s_ready_q is only ever set in the two load states, so it alone qualifies a handshake.
  assign hs_d     = s_valid & s_ready_q;
  assign final_d  = (state_q == LOAD_W) && (cnt_q == CNT_W'(W_LEN - 1));
  assign x_term_d = (state_q == LOAD_X) && (cnt_q == CNT_W'(X_LEN - 1));
  assign word_d   = (state_q == LOAD_X) ? ADDR_W'(X_BASE) + ADDR_W'(cnt_q)
                                        : ADDR_W'(W_BASE) + ADDR_W'(cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      owner_q   <= 1'b0;
      ntt_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= LOAD_X;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            ntt_rst_q <= 1'b1;
            owner_q   <= 1'b0;
          end
        end
        LOAD_X, LOAD_W: begin
          if (hs_d) begin
            if (s_last && !final_d) begin
              // Early s_last: abort without writing the offending word.
              state_q   <= IDLE;
              cnt_q     <= '0;
              err_q     <= 1'b1;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              en_q   <= 1'b1;
              we_q   <= 1'b1;
              addr_q <= word_d << 2;
              din_q  <= s_data;
              if (final_d) begin
                cnt_q     <= '0;
                s_ready_q <= 1'b0;
                if (s_last) begin
                  state_q <= RELEASE;
                end else begin
                  state_q <= IDLE;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                end
              end else if (x_term_d) begin
                state_q <= LOAD_W;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
        end
        RELEASE: begin
          state_q   <= WAIT_NTT;
          ntt_rst_q <= 1'b0;
          owner_q   <= 1'b1;
        end
        WAIT_NTT: begin
          if (ntt_done) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign BRAM_addr  = addr_q;
  assign BRAM_din   = din_q;
  assign BRAM_en    = en_q;
  assign BRAM_we    = we_q;
  assign bram_owner = owner_q;
  assign ntt_rst    = ntt_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire
